seq_pattern_tx: RTL and testbench

Serial pattern transmitter that generates the one-bit-per-clock `w` stream consumed by the team's sequence detector FSM. It lets the detector be exercised on-board or in simulation without hand-toggling a switch. A WIDTH-bit pattern is latched on `start` and shifted out MSB-first, repeated a programmable number of times with a programmable idle gap of forced-zero cycles. `busy` and `done` let a controller or bench sequence transmissions back to back.

---
 rtl/seq_pattern_tx.sv | 99 +++++++++
 tb/tb_seq_pattern_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// repeated a programmable number of times with forced-zero gaps between repetitions.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_GAP  = 3'd2,
        S_DONE = 3'd3
    } state_t;

    state_t           st_q;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] pat_sh;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_sh;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st_q      <= S_IDLE;
            shift_reg <= '0;
            pat_sh    <= '0;
            bit_cnt   <= '0;
            reps_left <= '0;
            gap_sh    <= '0;
            gap_cnt   <= '0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (start && (repeats != '0)) begin
                        shift_reg <= pattern;
                        pat_sh    <= pattern;
                        reps_left <= repeats;
                        gap_sh    <= gap;
                        bit_cnt   <= BW'(WIDTH - 1);
                        st_q      <= S_SEND;
                    end
                end
                S_SEND: begin
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        if (reps_left > CNT_W'(1)) begin
                            // Reload here so a zero gap streams the next repetition without a bubble.
                            reps_left <= reps_left - 1'b1;
                            shift_reg <= pat_sh;
                            bit_cnt   <= BW'(WIDTH - 1);
                            if (gap_sh != '0) begin
                                gap_cnt <= gap_sh;
                                st_q    <= S_GAP;
                            end
                        end else begin
                            st_q <= S_DONE;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) begin
                        st_q <= S_SEND;
                    end
                end
                S_DONE: begin
                    st_q <= S_IDLE;
                end
                default: begin
                    st_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_valid = (st_q == S_SEND);
    assign w       = w_valid & shift_reg[WIDTH-1];
    assign busy    = (st_q == S_SEND) || (st_q == S_GAP) || (st_q == S_DONE);
    assign done    = (st_q == S_DONE);
    assign state   = st_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: the driver pushes per-cycle expectations built
// from the pattern/repeat/gap rules; a negedge monitor pops and compares them.
module tb_seq_pattern_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic             clock;
    logic             resetn;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeats;
    logic [GAP_W-1:0] gap;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    typedef struct packed {
        logic       w;
        logic       v;
        logic       busy;
        logic       done;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   sample_n = 0;

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .pattern (pattern),
        .repeats (repeats),
        .gap     (gap),
        .w       (w),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic ew, input logic ev, input logic eb,
                                input logic ed, input logic [2:0] est);
        exp_t e;
        e.w = ew; e.v = ev; e.busy = eb; e.done = ed; e.st = est;
        return e;
    endfunction

    // Expected cycle stream of one job: R copies of the bits, G idle cycles between, then one done cycle.
    task automatic push_model(input logic [WIDTH-1:0] pat, input int r_cnt, input int g_cnt);
        for (int r = 0; r < r_cnt; r++) begin
            for (int i = WIDTH - 1; i >= 0; i--) q.push_back(mk(pat[i], 1'b1, 1'b1, 1'b0, 3'd1));
            if (r < r_cnt - 1)
                for (int g = 0; g < g_cnt; g++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd2));
        end
        if (r_cnt > 0) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 3'd3));
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            exp_t got;
            exp_t e;
            got = mk(w, w_valid, busy, done, state);
            checks++;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (got !== e)
                    begin
                        failures++;
                        $display("FAIL sb_sample%0d t=%0t got w=%b v=%b busy=%b done=%b st=%0d exp w=%b v=%b busy=%b done=%b st=%0d",
                                 sample_n, $time, got.w, got.v, got.busy, got.done, got.st,
                                 e.w, e.v, e.busy, e.done, e.st);
                    end
            end else if ({w, w_valid, busy, done, state} !== 7'd0) begin
                failures++;
                $display("FAIL idle_activity t=%0t got w=%b v=%b busy=%b done=%b st=%0d exp all 0",
                         $time, w, w_valid, busy, done, state);
            end
            sample_n++;
        end
    end

    // Called at posedge+2; leaves start low on return.
    task automatic wait_idle(input bit scramble);
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(posedge clock);
            #2;
            n++;
            if (scramble) begin
                start   = 1'($urandom_range(0, 1));
                pattern = WIDTH'($urandom);
                repeats = CNT_W'($urandom);
                gap     = GAP_W'($urandom);
            end
            if (n > 400) begin
                checks++;
                failures++;
                $display("FAIL job_timeout got pending=%0d exp pending=0", q.size());
                q.delete();
            end
        end
        start = 1'b0;
    endtask

    task automatic drive_job(input logic [WIDTH-1:0] pat, input int r_cnt, input int g_cnt,
                             input bit scramble);
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        push_model(pat, r_cnt, g_cnt);
        start   = 1'b1;
        pattern = pat;
        repeats = CNT_W'(r_cnt);
        gap     = GAP_W'(g_cnt);
        wait_idle(scramble);
    endtask

    task automatic check_zero(input string name, input logic [2:0] got);
        checks++;
        if (got !== 3'd0) begin
            failures++;
            $display("FAIL %s got=%0d exp=0", name, got);
        end
    endtask

    initial begin
        start   = 1'b0;
        pattern = '0;
        repeats = '0;
        gap     = '0;
        resetn  = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check_zero("rst_w", {2'b0, w});
        check_zero("rst_w_valid", {2'b0, w_valid});
        check_zero("rst_busy", {2'b0, busy});
        check_zero("rst_done", {2'b0, done});
        check_zero("rst_state", state);
        #6 resetn = 1'b1;
        repeat (2) @(posedge clock);
        #2;

        drive_job(8'b1101_1111, 1, 0, 1'b0);
        drive_job(8'hA5, 3, 2, 1'b0);
        drive_job(8'hF0, 2, 0, 1'b0);

        // repeats=0 requests are ignored for three cycles of start
        for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        start   = 1'b1;
        pattern = 8'hFF;
        repeats = '0;
        gap     = 3'd1;
        repeat (3) @(posedge clock);
        #2;
        start = 1'b0;
        wait_idle(1'b0);

        // start held high: second job picks up the pattern changed mid-first-job
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        push_model(8'hFF, 1, 0);
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        push_model(8'h00, 1, 0);
        start   = 1'b1;
        pattern = 8'hFF;
        repeats = 4'd1;
        gap     = 3'd0;
        repeat (3) @(posedge clock);
        #2;
        pattern = 8'h00;
        repeat (9) @(posedge clock);
        #2;
        start = 1'b0;
        wait_idle(1'b0);

        // asynchronous reset mid-SEND
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        push_model(8'hFF, 2, 1);
        start   = 1'b1;
        pattern = 8'hFF;
        repeats = 4'd2;
        gap     = 3'd1;
        @(posedge clock);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check_zero("arst_w", {2'b0, w});
        check_zero("arst_w_valid", {2'b0, w_valid});
        check_zero("arst_busy", {2'b0, busy});
        check_zero("arst_done", {2'b0, done});
        check_zero("arst_state", state);
        q.delete();
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        repeat (5) @(posedge clock);
        #2;

        for (int j = 0; j < 25; j++) begin
            drive_job(WIDTH'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 7)), 1'b1);
        end
        drive_job(8'h3C, 15, 7, 1'b1);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got pending=%0d exp pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
